// File: rtl/z80_regfile_banked_if.sv
// Bus between the Z80 decoder/sequencer (master) and the banked register file (slave).
// Carries the read/write addresses, write operation, ALU flags and all register-file outputs.
interface z80_regfile_banked_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] reg_read_1;
  logic [ADDR_W-1:0] reg_read_2;
  logic [ADDR_W-1:0] reg_write;
  logic [2:0]        reg_write_op;
  logic [7:0]        reg_in;
  logic [15:0]       reg_in16;
  logic [7:0]        reg_flags_write_en;
  logic [7:0]        alu_flags;
  logic              reg_pc_inc;
  logic              reg_r_inc;
  logic [7:0]        reg_out_1;
  logic [7:0]        reg_out_2;
  logic [15:0]       reg_out16_1;
  logic [15:0]       reg_pc;
  logic [15:0]       reg_sp;
  logic [7:0]        reg_out_flags;
  logic [3:0]        bank_state;

  modport master (
    output reg_read_1, reg_read_2, reg_write, reg_write_op, reg_in, reg_in16,
           reg_flags_write_en, alu_flags, reg_pc_inc, reg_r_inc,
    input  reg_out_1, reg_out_2, reg_out16_1, reg_pc, reg_sp, reg_out_flags, bank_state
  );

  modport slave (
    input  reg_read_1, reg_read_2, reg_write, reg_write_op, reg_in, reg_in16,
           reg_flags_write_en, alu_flags, reg_pc_inc, reg_r_inc,
    output reg_out_1, reg_out_2, reg_out16_1, reg_pc, reg_sp, reg_out_flags, bank_state
  );
endinterface

// File: rtl/z80_regfile_banked.sv
// Z80 register file with hardware AF/AF', EXX and EX DE,HL bank switching, masked flag
// update, PC/R increment and zero-latency reads with optional write-through bypass.
module z80_regfile_banked #(
  parameter int          ADDR_W   = 5,
  parameter int          NUM_TEMP = 4,
  parameter logic [15:0] RESET_SP = 16'hFFFF,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  z80_regfile_banked_if.slave bus
);

  localparam int unsigned NUM_ADDR  = 32'd1 << ADDR_W;
  localparam int unsigned IDX_ONE   = 32'd1;
  localparam int unsigned IDX_A     = 32'd2;
  localparam int unsigned IDX_F     = 32'd3;
  localparam int unsigned IDX_B     = 32'd4;
  localparam int unsigned IDX_C     = 32'd5;
  localparam int unsigned IDX_D     = 32'd6;
  localparam int unsigned IDX_E     = 32'd7;
  localparam int unsigned IDX_H     = 32'd8;
  localparam int unsigned IDX_L     = 32'd9;
  localparam int unsigned IDX_I     = 32'd10;
  localparam int unsigned IDX_R     = 32'd11;
  localparam int unsigned IDX_IXH   = 32'd12;
  localparam int unsigned IDX_IXL   = 32'd13;
  localparam int unsigned IDX_IYH   = 32'd14;
  localparam int unsigned IDX_IYL   = 32'd15;
  localparam int unsigned IDX_SPH   = 32'd16;
  localparam int unsigned IDX_SPL   = 32'd17;
  localparam int unsigned IDX_PCH   = 32'd18;
  localparam int unsigned IDX_PCL   = 32'd19;
  localparam int unsigned IDX_TEMP0 = 32'd20;

  localparam logic [2:0] OP_WR8     = 3'd1;
  localparam logic [2:0] OP_WR16    = 3'd2;
  localparam logic [2:0] OP_EX_AF   = 3'd3;
  localparam logic [2:0] OP_EXX     = 3'd4;
  localparam logic [2:0] OP_EX_DEHL = 3'd5;
  localparam logic [2:0] OP_LD_PC   = 3'd6;

  logic [7:0]  a_r [2];
  logic [7:0]  f_r [2];
  logic [7:0]  gp_r [2][6];
  logic [7:0]  i_r, r_r, ixh_r, ixl_r, iyh_r, iyl_r;
  logic [15:0] sp_r, pc_r;
  logic [7:0]  temp_r [NUM_TEMP];
  logic        af_bank_r;
  logic        gp_bank_r;
  logic [1:0]  dehl_swap_r;

  logic [NUM_ADDR-1:0] wr_en_s;
  logic [7:0]          wr_data_s  [NUM_ADDR];
  logic [7:0]          logical_s  [NUM_ADDR];
  logic [7:0]          view_s     [NUM_ADDR];
  logic [ADDR_W-1:0]   wr_hi_s, wr_lo_s, rd_hi_s, rd_lo_s;
  logic                swap_s;

  function automatic logic is_writable(input logic [ADDR_W-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    return ((ai >= IDX_A) && (ai <= IDX_PCL)) ||
           ((ai >= IDX_TEMP0) && (ai < IDX_TEMP0 + 32'(NUM_TEMP)));
  endfunction

  // Physical B,C,D,E,H,L slot; a set swap bit exchanges the DE and HL slots.
  function automatic logic [2:0] gp_slot(input int unsigned li, input logic swap);
    logic [2:0] slot;
    case (li)
      IDX_B:   slot = 3'd0;
      IDX_C:   slot = 3'd1;
      IDX_D:   slot = swap ? 3'd4 : 3'd2;
      IDX_E:   slot = swap ? 3'd5 : 3'd3;
      IDX_H:   slot = swap ? 3'd2 : 3'd4;
      IDX_L:   slot = swap ? 3'd3 : 3'd5;
      default: slot = 3'd0;
    endcase
    return slot;
  endfunction

  assign wr_hi_s = {bus.reg_write[ADDR_W-1:1], 1'b0};
  assign wr_lo_s = {bus.reg_write[ADDR_W-1:1], 1'b1};
  assign rd_hi_s = {bus.reg_read_1[ADDR_W-1:1], 1'b0};
  assign rd_lo_s = {bus.reg_read_1[ADDR_W-1:1], 1'b1};
  assign swap_s  = dehl_swap_r[gp_bank_r];

  // Decode this cycle's byte writes by logical address; unmapped targets never enable.
  always_comb begin
    wr_en_s = '0;
    for (int i = 0; i < int'(NUM_ADDR); i++) wr_data_s[i] = 8'h00;
    case (bus.reg_write_op)
      OP_WR8: begin
        wr_en_s[bus.reg_write]   = is_writable(bus.reg_write);
        wr_data_s[bus.reg_write] = bus.reg_in;
      end
      OP_WR16: begin
        wr_en_s[wr_hi_s]   = is_writable(wr_hi_s);
        wr_data_s[wr_hi_s] = bus.reg_in16[15:8];
        wr_en_s[wr_lo_s]   = is_writable(wr_lo_s);
        wr_data_s[wr_lo_s] = bus.reg_in16[7:0];
      end
      OP_LD_PC: begin
        wr_en_s[IDX_PCH]   = 1'b1;
        wr_data_s[IDX_PCH] = bus.reg_in16[15:8];
        wr_en_s[IDX_PCL]   = 1'b1;
        wr_data_s[IDX_PCL] = bus.reg_in16[7:0];
      end
      default: wr_en_s = '0;
    endcase
  end

  // Current logical register image through the bank/swap mapping, then bypass overlay.
  always_comb begin
    for (int i = 0; i < int'(NUM_ADDR); i++) logical_s[i] = 8'h00;
    logical_s[IDX_ONE] = 8'h01;
    logical_s[IDX_A]   = a_r[af_bank_r];
    logical_s[IDX_F]   = f_r[af_bank_r];
    for (int unsigned g = IDX_B; g <= IDX_L; g++)
      logical_s[g] = gp_r[gp_bank_r][gp_slot(g, swap_s)];
    logical_s[IDX_I]   = i_r;
    logical_s[IDX_R]   = r_r;
    logical_s[IDX_IXH] = ixh_r;
    logical_s[IDX_IXL] = ixl_r;
    logical_s[IDX_IYH] = iyh_r;
    logical_s[IDX_IYL] = iyl_r;
    logical_s[IDX_SPH] = sp_r[15:8];
    logical_s[IDX_SPL] = sp_r[7:0];
    logical_s[IDX_PCH] = pc_r[15:8];
    logical_s[IDX_PCL] = pc_r[7:0];
    for (int t = 0; t < NUM_TEMP; t++) logical_s[int'(IDX_TEMP0) + t] = temp_r[t];
    for (int i = 0; i < int'(NUM_ADDR); i++) begin
      if (BYPASS && wr_en_s[i] && !reset) view_s[i] = wr_data_s[i];
      else                                view_s[i] = logical_s[i];
    end
  end

  assign bus.reg_out_1     = view_s[bus.reg_read_1];
  assign bus.reg_out_2     = view_s[bus.reg_read_2];
  assign bus.reg_out16_1   = {view_s[rd_hi_s], view_s[rd_lo_s]};
  assign bus.reg_pc        = pc_r;
  assign bus.reg_sp        = sp_r;
  assign bus.reg_out_flags = f_r[af_bank_r];
  assign bus.bank_state    = {dehl_swap_r, gp_bank_r, af_bank_r};

  // Register state: writes, flag mask, PC/R increments and bank toggles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        a_r[b] <= 8'h00;
        f_r[b] <= 8'h00;
        for (int s = 0; s < 6; s++) gp_r[b][s] <= 8'h00;
      end
      i_r         <= 8'h00;
      r_r         <= 8'h00;
      ixh_r       <= 8'h00;
      ixl_r       <= 8'h00;
      iyh_r       <= 8'h00;
      iyl_r       <= 8'h00;
      sp_r        <= RESET_SP;
      pc_r        <= 16'h0000;
      for (int t = 0; t < NUM_TEMP; t++) temp_r[t] <= 8'h00;
      af_bank_r   <= 1'b0;
      gp_bank_r   <= 1'b0;
      dehl_swap_r <= 2'b00;
    end else begin
      if (wr_en_s[IDX_A]) a_r[af_bank_r] <= wr_data_s[IDX_A];
      // A full-byte write to F wins over the per-bit ALU mask.
      if (wr_en_s[IDX_F]) f_r[af_bank_r] <= wr_data_s[IDX_F];
      else f_r[af_bank_r] <= (f_r[af_bank_r] & ~bus.reg_flags_write_en) |
                             (bus.alu_flags & bus.reg_flags_write_en);
      for (int unsigned g = IDX_B; g <= IDX_L; g++)
        if (wr_en_s[g]) gp_r[gp_bank_r][gp_slot(g, swap_s)] <= wr_data_s[g];
      if (wr_en_s[IDX_I])   i_r   <= wr_data_s[IDX_I];
      if (wr_en_s[IDX_IXH]) ixh_r <= wr_data_s[IDX_IXH];
      if (wr_en_s[IDX_IXL]) ixl_r <= wr_data_s[IDX_IXL];
      if (wr_en_s[IDX_IYH]) iyh_r <= wr_data_s[IDX_IYH];
      if (wr_en_s[IDX_IYL]) iyl_r <= wr_data_s[IDX_IYL];
      if (wr_en_s[IDX_SPH]) sp_r[15:8] <= wr_data_s[IDX_SPH];
      if (wr_en_s[IDX_SPL]) sp_r[7:0]  <= wr_data_s[IDX_SPL];
      if (wr_en_s[IDX_PCH] || wr_en_s[IDX_PCL])
        pc_r <= {wr_en_s[IDX_PCH] ? wr_data_s[IDX_PCH] : pc_r[15:8],
                 wr_en_s[IDX_PCL] ? wr_data_s[IDX_PCL] : pc_r[7:0]};
      else if (bus.reg_pc_inc) pc_r <= pc_r + 16'd1;
      // Refresh counter: only the low seven bits count, bit 7 is preserved.
      if (wr_en_s[IDX_R]) r_r <= wr_data_s[IDX_R];
      else if (bus.reg_r_inc) r_r <= {r_r[7], r_r[6:0] + 7'd1};
      for (int t = 0; t < NUM_TEMP; t++)
        if (wr_en_s[int'(IDX_TEMP0) + t]) temp_r[t] <= wr_data_s[int'(IDX_TEMP0) + t];
      case (bus.reg_write_op)
        OP_EX_AF:   af_bank_r <= ~af_bank_r;
        OP_EXX:     gp_bank_r <= ~gp_bank_r;
        OP_EX_DEHL: dehl_swap_r[gp_bank_r] <= ~dehl_swap_r[gp_bank_r];
        default:    af_bank_r <= af_bank_r;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_regfile_banked.sv
// Directed bench for z80_regfile_banked: bank swaps, flag masking, PC/R priority, bypass, reset.
module tb_z80_regfile_banked;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  z80_regfile_banked_if bus ();

  z80_regfile_banked dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.reg_write_op       = 3'd0;
    bus.reg_write          = 5'd0;
    bus.reg_in             = 8'h00;
    bus.reg_in16           = 16'h0000;
    bus.reg_flags_write_en = 8'h00;
    bus.alu_flags          = 8'h00;
    bus.reg_pc_inc         = 1'b0;
    bus.reg_r_inc          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr8(input logic [4:0] a, input logic [7:0] d);
    bus.reg_write_op = 3'd1; bus.reg_write = a; bus.reg_in = d;
    tick();
  endtask

  task automatic wr16(input logic [4:0] a, input logic [15:0] d);
    bus.reg_write_op = 3'd2; bus.reg_write = a; bus.reg_in16 = d;
    tick();
  endtask

  task automatic do_op(input logic [2:0] op);
    bus.reg_write_op = op;
    tick();
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.reg_read_1 = a1;
    bus.reg_read_2 = a2;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.reg_read_1 = 5'd1;
    bus.reg_read_2 = 5'd0;
    #3;
    chk("rst_pc", bus.reg_pc, 16'h0000);
    chk("rst_sp", bus.reg_sp, 16'hFFFF);
    chk("rst_flags", {8'h00, bus.reg_out_flags}, 16'h0000);
    chk("rst_bank", {12'h000, bus.bank_state}, 16'h0000);
    chk("rst_one", {8'h00, bus.reg_out_1}, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // AF / AF' banking
    wr8(5'd2, 8'h12);
    wr8(5'd3, 8'h34);
    rd(5'd2, 5'd3);
    chk("a_12", {8'h00, bus.reg_out_1}, 16'h0012);
    chk("f_34", {8'h00, bus.reg_out_2}, 16'h0034);
    do_op(3'd3);
    chk("exaf_bank", {12'h000, bus.bank_state}, 16'h0001);
    chk("exaf_a0", {8'h00, bus.reg_out_1}, 16'h0000);
    wr16(5'd3, 16'hABCD);
    rd(5'd2, 5'd3);
    chk("af16", bus.reg_out16_1, 16'hABCD);
    do_op(3'd3);
    chk("back_a", {8'h00, bus.reg_out_1}, 16'h0012);
    chk("back_f", {8'h00, bus.reg_out_flags}, 16'h0034);
    do_op(3'd3);
    chk("alt_a", {8'h00, bus.reg_out_1}, 16'h00AB);
    chk("alt_f", {8'h00, bus.reg_out_2}, 16'h00CD);

    // DE/HL swap and EXX
    wr8(5'd6, 8'h11);
    wr8(5'd7, 8'h22);
    wr16(5'd8, 16'h3344);
    do_op(3'd5);
    rd(5'd6, 5'd7);
    chk("swap_d", {8'h00, bus.reg_out_1}, 16'h0033);
    chk("swap_e", {8'h00, bus.reg_out_2}, 16'h0044);
    chk("swap_bank", {12'h000, bus.bank_state}, 16'h0005);
    rd(5'd8, 5'd9);
    chk("swap_hl", bus.reg_out16_1, 16'h1122);
    do_op(3'd4);
    rd(5'd6, 5'd7);
    chk("exx_de", {bus.reg_out_1, bus.reg_out_2}, 16'h0000);
    chk("exx_bank", {12'h000, bus.bank_state}, 16'h0007);
    do_op(3'd4);
    chk("exx2_de", {bus.reg_out_1, bus.reg_out_2}, 16'h3344);

    // Flag mask vs full write
    wr8(5'd3, 8'h00);
    bus.reg_flags_write_en = 8'h81; bus.alu_flags = 8'hFF;
    wr8(5'd3, 8'h0F);
    chk("f_wr_wins", {8'h00, bus.reg_out_flags}, 16'h000F);
    bus.reg_flags_write_en = 8'h81; bus.alu_flags = 8'hFF;
    tick();
    chk("f_mask", {8'h00, bus.reg_out_flags}, 16'h008F);

    // PC load / increment / priority
    bus.reg_write_op = 3'd6; bus.reg_in16 = 16'hFFFF;
    tick();
    chk("pc_ld", bus.reg_pc, 16'hFFFF);
    bus.reg_pc_inc = 1'b1; tick();
    chk("pc_wrap", bus.reg_pc, 16'h0000);
    bus.reg_pc_inc = 1'b1; tick();
    chk("pc_inc", bus.reg_pc, 16'h0001);
    bus.reg_pc_inc = 1'b1; bus.reg_write_op = 3'd6; bus.reg_in16 = 16'h1234;
    tick();
    chk("pc_ld_wins", bus.reg_pc, 16'h1234);
    rd(5'd18, 5'd19);
    chk("pc_rd", {bus.reg_out_1, bus.reg_out_2}, 16'h1234);

    // R refresh counter
    wr8(5'd11, 8'hFF);
    bus.reg_r_inc = 1'b1; tick();
    rd(5'd11, 5'd1);
    chk("r_wrap", {8'h00, bus.reg_out_1}, 16'h0080);
    bus.reg_r_inc = 1'b1;
    wr8(5'd11, 8'h05);
    chk("r_wr_wins", {8'h00, bus.reg_out_1}, 16'h0005);

    // NULL / ONE / temps / unmapped
    rd(5'd0, 5'd1);
    bus.reg_write_op = 3'd1; bus.reg_write = 5'd0; bus.reg_in = 8'h55;
    #1;
    chk("null_byp", {8'h00, bus.reg_out_1}, 16'h0000);
    tick();
    chk("null_one", {bus.reg_out_1, bus.reg_out_2}, 16'h0001);
    wr8(5'd20, 8'h77);
    wr8(5'd23, 8'h66);
    wr8(5'd24, 8'h99);
    rd(5'd20, 5'd23);
    chk("temps", {bus.reg_out_1, bus.reg_out_2}, 16'h7766);
    rd(5'd24, 5'd30);
    chk("unmapped", {bus.reg_out_1, bus.reg_out_2}, 16'h0000);

    // Bypass of a write into the read address
    rd(5'd4, 5'd4);
    bus.reg_write_op = 3'd1; bus.reg_write = 5'd4; bus.reg_in = 8'h5A;
    #1;
    chk("bypass", {8'h00, bus.reg_out_1}, 16'h005A);
    tick();
    chk("b_held", {8'h00, bus.reg_out_2}, 16'h005A);

    // Reset in the middle of activity
    wr16(5'd16, 16'h1234);
    chk("sp_wr", bus.reg_sp, 16'h1234);
    bus.reg_write_op = 3'd1; bus.reg_write = 5'd4; bus.reg_in = 8'h77;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_sp", bus.reg_sp, 16'hFFFF);
    chk("mid_pc", bus.reg_pc, 16'h0000);
    chk("mid_b", {8'h00, bus.reg_out_1}, 16'h0000);
    chk("mid_bank", {12'h000, bus.bank_state}, 16'h0000);
    chk("mid_flags", {8'h00, bus.reg_out_flags}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
